// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide unit that sits in the E stage of the five-stage
// MIPS pipeline.
//
// The unit owns the architectural HI/LO registers. It executes
// MULT/MULTU/DIV/DIVU with a fixed, parameterised latency, and it services
// MTHI/MTLO.
//
// On issue, the full 64-bit result is computed combinationally and parked in
// tmp_hi/tmp_lo. A down-counter then holds the unit busy until the result is
// committed to HI/LO.
//
// Parameters:
//   MUL_LAT  cycles a multiply (or accumulate) occupies the unit, 1..31
//   DIV_LAT  cycles a divide occupies the unit, 1..31
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   Start_E  mul/div instruction in E this cycle (qualified by MDOp_E)
//   MDOp_E   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 1xx accumulate family
//   A_E      rs operand (already forwarded)
//   B_E      rt operand (already forwarded)
//   MTHI_E   write A_E into HI
//   MTLO_E   write A_E into LO
//   Busy     unit occupied; ANDed with the mul/div decode by the stall logic
//   HI, LO   current architectural HI/LO registers
//
// Optional feature:
//   Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 1xx).
//   Without it, 1xx is treated as an invalid op. It is then ignored and does
//   not raise Busy, and the accumulator adder is not built.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start_E,
    input  logic [2:0]  MDOp_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        MTHI_E,
    input  logic        MTLO_E,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [4:0] MUL_CNT = 5'(MUL_LAT);
    localparam logic [4:0] DIV_CNT = 5'(DIV_LAT);

    logic [0:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] tmp_hi_q, tmp_hi_d;
    logic [31:0] tmp_lo_q, tmp_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        valid_op;
    logic [63:0] a_sx, b_sx;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, mag_q, mag_r;
    logic [31:0] s_quo, s_rem;
    logic [31:0] u_quo, u_rem;
    logic [63:0] result;
    logic [4:0]  op_lat;

    // Decide whether the opcode is one this build can execute.
    always_comb begin
`ifdef MULDIV_MADD_EN
        valid_op = 1'b1;
`else
        valid_op = ~MDOp_E[2];
`endif
    end

    // Products.
    // The low 64 bits of a 64x64 multiply of sign-extended operands equal
    // the signed 32x32 product.
    always_comb begin
        a_sx   = {{32{A_E[31]}}, A_E};
        b_sx   = {{32{B_E[31]}}, B_E};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, A_E} * {32'd0, B_E};
    end

    // Divides.
    // The signed divide works on magnitudes and then restores the signs.
    // The quotient is negated when the operand signs differ, and the
    // remainder follows the sign of the dividend.
    // For 0x80000000 / -1, the magnitude quotient is 2^31. Its 32-bit
    // pattern is 0x80000000, which is the required result.
    always_comb begin
        a_mag = A_E[31] ? (~A_E + 32'd1) : A_E;
        b_mag = B_E[31] ? (~B_E + 32'd1) : B_E;
        mag_q = a_mag / b_mag;
        mag_r = a_mag % b_mag;
        s_quo = (A_E[31] ^ B_E[31]) ? (~mag_q + 32'd1) : mag_q;
        s_rem = A_E[31] ? (~mag_r + 32'd1) : mag_r;
        u_quo = A_E / B_E;
        u_rem = A_E % B_E;
    end

`ifdef MULDIV_MADD_EN
    logic [63:0] acc_prod;
    logic [63:0] acc_res;

    // One shared adder/subtractor.
    // MDOp_E[0] picks the unsigned product, and MDOp_E[1] picks subtract.
    // The accumulator base is HI/LO as of issue.
    always_comb begin
        acc_prod = MDOp_E[0] ? prod_u : prod_s;
        acc_res  = MDOp_E[1] ? ({hi_q, lo_q} - acc_prod) : ({hi_q, lo_q} + acc_prod);
    end
`endif

    // Select the 64-bit {HI,LO} result for the op being issued.
    // A divide by zero returns LO = all ones and HI = the dividend.
    always_comb begin
        result = 64'd0;
        case (MDOp_E)
            3'b000: result = prod_s;
            3'b001: result = prod_u;
            3'b010: result = (B_E == 32'd0) ? {A_E, 32'hFFFF_FFFF} : {s_rem, s_quo};
            3'b011: result = (B_E == 32'd0) ? {A_E, 32'hFFFF_FFFF} : {u_rem, u_quo};
`ifdef MULDIV_MADD_EN
            3'b100, 3'b101, 3'b110, 3'b111: result = acc_res;
`endif
            default: result = 64'd0;
        endcase
        op_lat = (MDOp_E[2:1] == 2'b01) ? DIV_CNT : MUL_CNT;
    end

    // Next-state logic.
    // In IDLE, a valid Start launches an operation and takes priority
    // over MTHI/MTLO.
    // In RUN, the counter runs down. The edge where it reaches 1
    // commits the parked result and returns to IDLE.
    // Start and MT requests seen during RUN are dropped.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == ST_IDLE) begin
            if (Start_E) begin
                if (valid_op) begin
                    tmp_hi_d = result[63:32];
                    tmp_lo_d = result[31:0];
                    cnt_d    = op_lat;
                    state_d  = ST_RUN;
                end
            end else begin
                if (MTHI_E) begin
                    hi_d = A_E;
                end
                if (MTLO_E) begin
                    lo_d = A_E;
                end
            end
        end else begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                hi_d    = tmp_hi_q;
                lo_d    = tmp_lo_q;
                cnt_d   = 5'd0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Busy rises in the issue cycle itself, so the hazard logic can stall
    // the very next HI/LO consumer.
    assign Busy = (Start_E & valid_op) | (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit.
//
// Expected HI/LO values come from a behavioural model of the instruction
// semantics, written with plain 64-bit integer arithmetic. The model
// tracks the architectural HI/LO in modelHi/modelLo.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Start_E;
    logic [2:0]  MDOp_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        MTHI_E;
    logic        MTLO_E;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    // Free-running clock; rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    muldiv_unit #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .Start_E(Start_E),
        .MDOp_E (MDOp_E),
        .A_E    (A_E),
        .B_E    (B_E),
        .MTHI_E (MTHI_E),
        .MTLO_E (MTLO_E),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Architectural result of an op given its operands and the current
    // {HI,LO}.
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'b000: return 64'(sa * sb);
            3'b001: return ua * ub;
            3'b010: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'b011: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'b100: return acc + 64'(sa * sb);
            3'b101: return acc + ua * ub;
            3'b110: return acc - 64'(sa * sb);
            default: return acc - ua * ub;
        endcase
    endfunction

    function automatic int latOf(input logic [2:0] op);
        return (op == 3'b010 || op == 3'b011) ? DIV_LAT : MUL_LAT;
    endfunction

    // Issue one op in the current cycle and follow it to commit.
    // On return the bench sits in the first cycle after commit, with
    // Start_E low. A following call therefore issues back-to-back.
    // With mtDuring set, MTHI/MTLO are held high through the whole run;
    // the unit must ignore them.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit mtDuring);
        logic [63:0] expRes;
        int          lat;
        expRes  = refResult(op, a, b, {modelHi, modelLo});
        lat     = latOf(op);
        Start_E = 1'b1;
        MDOp_E  = op;
        A_E     = a;
        B_E     = b;
        #1;
        checkOutput("busy_issue", 64'(Busy), 64'd1);
        @(posedge clk);
        #1;
        Start_E = 1'b0;
        A_E     = $urandom;
        B_E     = $urandom;
        for (int i = 1; i <= lat; i++) begin
            if (mtDuring) begin
                MTHI_E = 1'b1;
                MTLO_E = 1'b1;
            end
            #1;
            checkOutput("busy_run", 64'(Busy), 64'd1);
            if (i == lat) begin
                checkOutput("hilo_hold", {HI, LO}, {modelHi, modelLo});
            end
            @(posedge clk);
            #1;
        end
        MTHI_E = 1'b0;
        MTLO_E = 1'b0;
        #1;
        checkOutput("busy_done", 64'(Busy), 64'd0);
        checkOutput("hilo_result", {HI, LO}, expRes);
        {modelHi, modelLo} = expRes;
    endtask

    // MTHI/MTLO from IDLE; the new value is visible after the edge.
    task automatic mtWrite(input bit doHi, input bit doLo, input logic [31:0] val);
        MTHI_E = doHi;
        MTLO_E = doLo;
        A_E    = val;
        @(posedge clk);
        #1;
        MTHI_E = 1'b0;
        MTLO_E = 1'b0;
        if (doHi) modelHi = val;
        if (doLo) modelLo = val;
        #1;
        checkOutput("mt_write", {HI, LO}, {modelHi, modelLo});
    endtask

    initial begin
        logic [2:0]  rOp;
        logic [31:0] rA, rB;

        // Reset held with a MULT request pending: Busy follows Start only.
        reset_n = 1'b0;
        Start_E = 1'b1;
        MDOp_E  = 3'b000;
        A_E     = 32'd3;
        B_E     = 32'd4;
        MTHI_E  = 1'b0;
        MTLO_E  = 1'b0;
        modelHi = 32'd0;
        modelLo = 32'd0;
        #2;
        checkOutput("reset_busy_start", 64'(Busy), 64'd1);
        checkOutput("reset_hilo", {HI, LO}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_hilo_held", {HI, LO}, 64'd0);
        Start_E = 1'b0;
        reset_n = 1'b1;
        #1;
        checkOutput("reset_idle_busy", 64'(Busy), 64'd0);
        @(posedge clk);
        #2;
        checkOutput("post_reset_busy", 64'(Busy), 64'd0);

        // Reset asserted mid-RUN aborts the op and clears HI/LO at once.
        mtWrite(1'b1, 1'b0, 32'h0000_DEAD);
        mtWrite(1'b0, 1'b1, 32'h0000_BEEF);
        Start_E = 1'b1;
        MDOp_E  = 3'b000;
        A_E     = 32'd3;
        B_E     = 32'd4;
        @(posedge clk);
        #1;
        Start_E = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrun_reset_hilo", {HI, LO}, 64'd0);
        checkOutput("midrun_reset_busy", 64'(Busy), 64'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (MUL_LAT + 2) @(posedge clk);
        #1;
        checkOutput("aborted_busy", 64'(Busy), 64'd0);
        checkOutput("aborted_hilo", {HI, LO}, 64'd0);

        // Directed cases with hand-computed results.
        applyStimulus(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0);
        checkOutput("mult_neg2x3", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        applyStimulus(3'b011, 32'd100, 32'd7, 1'b0);
        checkOutput("divu_100_7", {HI, LO}, {32'd2, 32'd14});
        applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        checkOutput("div_m7_2", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(3'b011, 32'd5, 32'd0, 1'b0);
        checkOutput("divu_by_zero", {HI, LO}, {32'd5, 32'hFFFF_FFFF});
        applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checkOutput("div_overflow", {HI, LO}, {32'd0, 32'h8000_0000});
        mtWrite(1'b1, 1'b0, 32'h0000_1234);
        checkOutput("mthi_1234", 64'(HI), 64'h1234);

        // MT held during RUN, then an immediate back-to-back issue.
        applyStimulus(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        applyStimulus(3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        checkOutput("mult_min_sq", {HI, LO}, 64'h4000_0000_0000_0000);

`ifdef MULDIV_MADD_EN
        mtWrite(1'b1, 1'b0, 32'd0);
        mtWrite(1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(3'b101, 32'd1, 32'd1, 1'b0);
        checkOutput("maddu_carry", {HI, LO}, {32'd1, 32'd0});
`else
        // An accumulate opcode is invalid in this build: no Busy, no effect.
        Start_E = 1'b1;
        MDOp_E  = 3'b100;
        A_E     = 32'd7;
        B_E     = 32'd9;
        #1;
        checkOutput("invalid_op_busy", 64'(Busy), 64'd0);
        @(posedge clk);
        #1;
        Start_E = 1'b0;
        #1;
        checkOutput("invalid_op_busy_after", 64'(Busy), 64'd0);
        checkOutput("invalid_op_hilo", {HI, LO}, {modelHi, modelLo});
`endif

        // Randomised ops against the model, with corner-biased operands.
        for (int n = 0; n < 40; n++) begin
`ifdef MULDIV_MADD_EN
            rOp = 3'($urandom_range(0, 7));
`else
            rOp = 3'($urandom_range(0, 3));
`endif
            rA = $urandom;
            rB = $urandom;
            case ($urandom_range(0, 3))
                0: rB = 32'd0;
                1: begin
                    rA = 32'($urandom_range(0, 200)) - 32'd100;
                    rB = 32'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) rB = ~rB + 32'd1;
                end
                2: begin
                    rA = 32'h8000_0000;
                    if ($urandom_range(0, 1) == 1) rB = 32'hFFFF_FFFF;
                end
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                mtWrite(1'b1, 1'b1, $urandom);
            end
            applyStimulus(rOp, rA, rB, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
